seq_divider_32bit: RTL

SEQ_DIVIDER_32BIT -- requirements
Module: seq_divider_32bit

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_sub_step.sv | 18 +
 rtl/seq_divider_32bit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the sequential 32-bit divider.
// Holds the op and FSM encodings plus a conditional-negate helper.
package div_pkg;

  localparam int XLEN        = 32;
  localparam int DIV_ITER    = 32;
  localparam int DIV_LATENCY = 33;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// Combinational trial subtract for one restoring-division step.
// Borrow is the sign of the zero-extended difference.
module div_sub_step #(
  parameter int W = 32
) (
  input  logic [W:0]   partial_rem,
  input  logic [W-1:0] divisor,
  output logic [W:0]   diff,
  output logic         borrow
);

  logic [W+1:0] full;

  assign full   = {1'b0, partial_rem} - {2'b00, divisor};
  assign diff   = full[W:0];
  assign borrow = full[W+1];

endmodule

// File: rtl/seq_divider_32bit.sv
// Sequential restoring divider: one quotient bit per cycle, fixed 33-cycle latency.
// Valid/ready: a request is taken only when o_busy=0 and i_start=1 on a rising edge; o_valid is a one-cycle result strobe.
module seq_divider_32bit #(
  parameter int XLEN = div_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_div_by_zero
);

  import div_pkg::*;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  div_op_e          op_q, op_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic [XLEN-1:0]  divisor_q, divisor_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             valid_q, valid_d;
  logic             dbz_out_q, dbz_out_d;

  logic [XLEN:0]    partial;
  logic [XLEN:0]    diff;
  logic             borrow;
  logic             unused_diff_msb;
  logic             signed_op;
  logic [XLEN-1:0]  quo_fix;
  logic [XLEN-1:0]  rem_fix;
  logic [XLEN-1:0]  final_res;

  assign partial         = {rem_q, quo_q[XLEN-1]};
  // With no borrow the difference is below the divisor, so its MSB is always 0.
  assign unused_diff_msb = diff[XLEN];

  div_sub_step #(.W(XLEN)) u_sub (
    .partial_rem (partial),
    .divisor     (divisor_q),
    .diff        (diff),
    .borrow      (borrow)
  );

  assign signed_op = ~i_op[0];
  assign quo_fix   = cond_neg(quo_q, (op_q == OP_DIV) && (a_neg_q ^ b_neg_q));
  assign rem_fix   = cond_neg(rem_q, (op_q == OP_REM) && a_neg_q);

  // On divide-by-zero the remainder path naturally reproduces the dividend.
  always_comb begin
    final_res = '0;
    unique case (op_q)
      OP_DIV, OP_DIVU: begin
        if (dbz_q)      final_res = '1;
        else if (ovf_q) final_res = {1'b1, {(XLEN-1){1'b0}}};
        else            final_res = quo_fix;
      end
      OP_REM, OP_REMU: begin
        if (dbz_q)      final_res = rem_fix;
        else if (ovf_q) final_res = '0;
        else            final_res = rem_fix;
      end
      default: final_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    dbz_out_d = dbz_out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_CALC;
          cnt_d     = '0;
          op_d      = div_op_e'(i_op);
          a_neg_d   = signed_op & i_dividend[XLEN-1];
          b_neg_d   = signed_op & i_divisor[XLEN-1];
          quo_d     = cond_neg(i_dividend, signed_op & i_dividend[XLEN-1]);
          divisor_d = cond_neg(i_divisor, signed_op & i_divisor[XLEN-1]);
          rem_d     = '0;
          dbz_d     = (i_divisor == '0);
          ovf_d     = signed_op && (i_dividend == {1'b1, {(XLEN-1){1'b0}}}) && (i_divisor == '1);
        end
      end
      ST_CALC: begin
        rem_d = borrow ? partial[XLEN-1:0] : diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ~borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        // First DONE cycle registers the result; the strobe cycle then returns to IDLE.
        if (!valid_q) begin
          valid_d   = 1'b1;
          result_d  = final_res;
          dbz_out_d = dbz_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_DIV;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign o_busy        = (state_q != ST_IDLE);
  assign o_valid       = valid_q;
  assign o_result      = result_q;
  assign o_div_by_zero = dbz_out_q;

endmodule
